// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, signed or unsigned per op.
// Optional macro DIV_ZERO_BYPASS_EN: a zero divisor skips the iteration phase.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             op_done,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, FIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted, trial;
    logic             a_neg, b_neg;

    assign shifted = {prem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign a_neg   = signed_op & dividend[WIDTH-1];
    assign b_neg   = signed_op & divisor[WIDTH-1];

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        orig_d  = orig_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    dvd_d  = a_neg ? -dividend : dividend;
                    dvs_d  = b_neg ? -divisor : divisor;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    zero_d = (divisor == '0);
                    orig_d = dividend;
                    prem_d = '0;
                    cnt_d  = '0;
`ifdef DIV_ZERO_BYPASS_EN
                    state_d = (divisor == '0) ? FIN : EXEC;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                // trial[WIDTH] is the sign of the trial subtraction
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = FIN;
            end
            FIN: begin
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = orig_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = qneg_q ? -dvd_q : dvd_q;
                    rem_d  = rneg_q ? -prem_q : prem_q;
                    dbz_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            orig_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            orig_q  <= orig_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == EXEC) || (state_q == FIN);
    assign op_done     = (state_q == DONE);

endmodule
